rv_mem_arbiter: RTL and testbench

- Shares one single-ported memory between the core's instruction-fetch port and its load/store data port, for builds with a unified instruction/data SRAM.
- Sits between the core (fetch and data requesters) and the memory.
- Uses a req/gnt/rvalid protocol on every side, allows one outstanding transaction, and gives data priority over fetch with a starvation bound.

---
 rtl/rv_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rv_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arbiter.sv
// Arbitrates one single-ported memory between the instruction-fetch and load/store ports; data has priority, fetch wins after MAX_STARVE data grants.
// Optional response timeout with error flag is built when RV_ARB_TIMEOUT_EN is defined.
module rv_mem_arbiter #(
  parameter int unsigned MAX_STARVE     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, RESP} state_e;
  typedef enum logic {OWN_DATA = 1'b0, OWN_INSTR = 1'b1} owner_e;

  localparam int unsigned SW = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  logic sel_instr;
  logic drive_req;
  logic grant;
  logic rvalid;
  logic err;
  logic timeout_hit;

`ifdef RV_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Counts RESP cycles; zero in the first RESP cycle, so the timeout fires in RESP cycle TIMEOUT_CYCLES.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == RESP) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_hit = (state_q == RESP) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  // No timeout logic; RESP waits for mem_rvalid_i indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES == 32'd0) && 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    sel_instr    = (owner_q == OWN_INSTR);
    drive_req    = 1'b0;
    grant        = 1'b0;
    rvalid       = 1'b0;
    err          = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_req_i || data_req_i) begin
          sel_instr = instr_req_i && (!data_req_i || (starve_cnt_q == STARVE_MAX));
          drive_req = 1'b1;
          grant     = mem_gnt_i;
          owner_d   = sel_instr ? OWN_INSTR : OWN_DATA;
          state_d   = mem_gnt_i ? RESP : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        drive_req = 1'b1;
        grant     = mem_gnt_i;
        if (mem_gnt_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid_i || timeout_hit) begin
          rvalid  = 1'b1;
          err     = timeout_hit && !mem_rvalid_i;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      if (sel_instr || !instr_req_i) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= OWN_DATA;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Request-side outputs are masked while reset is held so nothing leaks from live requester inputs.
  always_comb begin
    mem_req_o   = drive_req && !rst_i;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (drive_req && !rst_i) begin
      if (sel_instr) begin
        mem_be_o   = 4'hF;
        mem_addr_o = instr_addr_i;
      end else begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end
    end
  end

  assign instr_gnt_o    = grant && sel_instr && !rst_i;
  assign data_gnt_o     = grant && !sel_instr && !rst_i;
  assign instr_rvalid_o = rvalid && (owner_q == OWN_INSTR);
  assign data_rvalid_o  = rvalid && (owner_q == OWN_DATA);
  assign instr_err_o    = err && (owner_q == OWN_INSTR);
  assign data_err_o     = err && (owner_q == OWN_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Scoreboard bench for rv_mem_arbiter: random traffic plus directed scenarios, checked against a transaction-level arbitration model.
module tb_rv_mem_arbiter;
  localparam int MAXS = 4;
  localparam int TOC  = 8;
`ifdef RV_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = 32'h0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'h0;
  logic [31:0] data_addr_i = 32'h0;
  logic [31:0] data_wdata_i = 32'h0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  rv_mem_arbiter #(.MAX_STARVE(MAXS), .TIMEOUT_CYCLES(TOC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    bit          instr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct packed {
    bit          instr;
    logic [31:0] rdata;
    bit          err;
  } rsp_t;

  gnt_t exp_gnt_q[$];
  rsp_t exp_rsp_q[$];
  bit   grant_log[$];
  int   total = 0;
  int   bad   = 0;
  bit   exp_mem_req = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Reference model: one transaction in flight at a time; the decision who goes next is made when the
  // memory port is free, data first unless fetch has been passed over MAXS times in a row.
  initial begin
    bit m_locked, m_inflight, m_owner_instr;
    int m_starve, m_age;
    m_locked = 0; m_inflight = 0; m_owner_instr = 0; m_starve = 0; m_age = 0;
    forever begin
      @(negedge clk_i);
      exp_mem_req = 1'b0;
      if (rst_i) begin
        m_locked = 0; m_inflight = 0; m_starve = 0; m_age = 0;
      end else if (m_inflight) begin
        if (mem_rvalid_i) begin
          exp_rsp_q.push_back('{instr: m_owner_instr, rdata: mem_rdata_i, err: 1'b0});
          m_inflight = 0;
        end else if (TO_EN && m_age == TOC - 1) begin
          exp_rsp_q.push_back('{instr: m_owner_instr, rdata: 32'h0, err: 1'b1});
          m_inflight = 0;
        end else begin
          m_age++;
        end
      end else begin
        if (!m_locked && (instr_req_i || data_req_i)) begin
          m_owner_instr = instr_req_i && (!data_req_i || m_starve == MAXS);
          m_locked = 1;
        end
        if (m_locked) begin
          exp_mem_req = 1'b1;
          if (mem_gnt_i) begin
            if (m_owner_instr)
              exp_gnt_q.push_back('{instr: 1'b1, we: 1'b0, be: 4'hF, addr: instr_addr_i, wdata: 32'h0});
            else
              exp_gnt_q.push_back('{instr: 1'b0, we: data_we_i, be: data_be_i, addr: data_addr_i, wdata: data_wdata_i});
            if (m_owner_instr || !instr_req_i) m_starve = 0;
            else m_starve = (m_starve + 1 > MAXS) ? MAXS : m_starve + 1;
            m_locked = 0; m_inflight = 1; m_age = 0;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant or a response.
  initial begin
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clk_i);
      #1;
      check("mem_req", 32'(mem_req_o), 32'(exp_mem_req));
      if (instr_gnt_o || data_gnt_o || (mem_req_o && mem_gnt_i)) begin
        if (exp_gnt_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_grant: instr_gnt=%0b data_gnt=%0b, required no grant", instr_gnt_o, data_gnt_o);
        end else begin
          g = exp_gnt_q.pop_front();
          check("gnt_instr", 32'(instr_gnt_o), 32'(g.instr));
          check("gnt_data", 32'(data_gnt_o), 32'(!g.instr));
          check("mem_we", 32'(mem_we_o), 32'(g.we));
          check("mem_be", 32'(mem_be_o), 32'(g.be));
          check("mem_addr", mem_addr_o, g.addr);
          check("mem_wdata", mem_wdata_o, g.wdata);
          grant_log.push_back(g.instr);
          $display("grant %s addr=0x%08h we=%0b be=0x%h wdata=0x%08h", g.instr ? "instr" : "data ", g.addr, g.we, g.be, g.wdata);
        end
      end else if (exp_gnt_q.size() != 0) begin
        g = exp_gnt_q.pop_front();
        total++; bad++;
        $display("FAIL missing_grant: no grant seen, required %s grant addr=0x%08h", g.instr ? "instr" : "data", g.addr);
      end
      if (instr_rvalid_o || data_rvalid_o) begin
        if (exp_rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rvalid: instr_rvalid=%0b data_rvalid=%0b, required none", instr_rvalid_o, data_rvalid_o);
        end else begin
          r = exp_rsp_q.pop_front();
          check("rvalid_instr", 32'(instr_rvalid_o), 32'(r.instr));
          check("rvalid_data", 32'(data_rvalid_o), 32'(!r.instr));
          check("err_instr", 32'(instr_err_o), 32'(r.instr && r.err));
          check("err_data", 32'(data_err_o), 32'(!r.instr && r.err));
          if (!r.err) check("rdata", r.instr ? instr_rdata_o : data_rdata_o, r.rdata);
          $display("resp  %s rdata=0x%08h err=%0b", r.instr ? "instr" : "data ", r.rdata, r.err);
        end
      end else if (exp_rsp_q.size() != 0) begin
        r = exp_rsp_q.pop_front();
        total++; bad++;
        $display("FAIL missing_rvalid: no rvalid seen, required %s response", r.instr ? "instr" : "data");
      end
    end
  end

  bit resp_pend = 1'b0;
  int resp_lat  = 0;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
    #2;
  endtask

  task automatic rand_cycle(input bit new_reqs);
    logic ig, dg, acc;
    @(negedge clk_i);
    ig  = instr_gnt_o;
    dg  = data_gnt_o;
    acc = mem_req_o && mem_gnt_i;
    if (acc) begin
      resp_pend = 1'b1;
      resp_lat  = int'($urandom_range(0, 3));
    end
    step();
    if (instr_req_i && ig) instr_req_i = 1'b0;
    if (data_req_i && dg) data_req_i = 1'b0;
    if (new_reqs && !instr_req_i && $urandom_range(0, 1) == 1) begin
      instr_req_i  = 1'b1;
      instr_addr_i = $urandom & 32'hFFFF_FFFC;
    end
    if (new_reqs && !data_req_i && $urandom_range(0, 1) == 1) begin
      data_req_i   = 1'b1;
      data_we_i    = 1'($urandom_range(0, 1));
      data_be_i    = 4'($urandom_range(1, 15));
      data_addr_i  = $urandom & 32'hFFFF_FFFC;
      data_wdata_i = $urandom;
    end
    mem_gnt_i    = ($urandom_range(0, 9) < 6);
    mem_rvalid_i = 1'b0;
    if (resp_pend) begin
      if (resp_lat == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = $urandom;
        resp_pend    = 1'b0;
      end else begin
        resp_lat--;
      end
    end else if ($urandom_range(0, 15) == 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = $urandom;
    end
  endtask

  task automatic all_idle();
    instr_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  initial begin
    int guard;
    // Reset state
    repeat (2) @(negedge clk_i);
    #2;
    check("rst_instr_gnt", 32'(instr_gnt_o), 32'h0);
    check("rst_data_gnt", 32'(data_gnt_o), 32'h0);
    check("rst_rvalid", 32'({instr_rvalid_o, data_rvalid_o}), 32'h0);
    check("rst_err", 32'({instr_err_o, data_err_o}), 32'h0);
    check("rst_mem_req_we", 32'({mem_req_o, mem_we_o}), 32'h0);
    check("rst_mem_be", 32'(mem_be_o), 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_wdata", mem_wdata_o, 32'h0);
    step();
    rst_i = 1'b0;
    step();

    // Randomized traffic, then drain
    repeat (1500) rand_cycle(1'b1);
    guard = 0;
    while ((instr_req_i || data_req_i || resp_pend) && guard < 200) begin
      rand_cycle(1'b0);
      guard++;
    end
    if (guard >= 200) begin
      total++; bad++;
      $display("FAIL drain_timeout: requests still pending after %0d cycles, required drained", guard);
    end
    step(); all_idle();
    step(); step();

    // Fetch only, granted and answered back to back
    step(); instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
    at_neg(); check("t1_instr_gnt_c0", 32'(instr_gnt_o), 32'h1);
    step(); instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    at_neg();
    check("t1_instr_rvalid_c1", 32'(instr_rvalid_o), 32'h1);
    check("t1_instr_rdata_c1", instr_rdata_o, 32'hDEADBEEF);
    check("t1_mem_req_c1", 32'(mem_req_o), 32'h0);
    step(); mem_rvalid_i = 1'b0;

    // Simultaneous fetch and store: store first
    step();
    instr_req_i = 1'b1; instr_addr_i = 32'h104;
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3; data_addr_i = 32'h200; data_wdata_i = 32'h1234;
    mem_gnt_i = 1'b1;
    at_neg();
    check("t2_data_gnt", 32'(data_gnt_o), 32'h1);
    check("t2_instr_gnt", 32'(instr_gnt_o), 32'h0);
    check("t2_mem_we", 32'(mem_we_o), 32'h1);
    check("t2_mem_be", 32'(mem_be_o), 32'h3);
    step(); data_req_i = 1'b0; data_we_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
    step();
    at_neg(); check("t2_instr_gnt_next_idle", 32'(instr_gnt_o), 32'h1);
    step(); instr_req_i = 1'b0; mem_rdata_i = 32'hA5A5A5A5;
    step(); mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;

    // Both held continuously: DDDDI repeating
    grant_log.delete();
    step();
    instr_req_i = 1'b1; instr_addr_i = 32'h108;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h20C; data_wdata_i = 32'h0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    repeat (19) begin
      step(); mem_rdata_i = $urandom;
    end
    step(); all_idle();
    at_neg();
    check("t3_grant_count", 32'(grant_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      check($sformatf("t3_grant_order_%0d", i), 32'(grant_log[i]), 32'((i % 5) == 4));

    // Memory stalls a waiting data request; fetch arriving meanwhile must not steal it
    step(); data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h300;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        instr_req_i = 1'b1; instr_addr_i = 32'h400;
      end
      at_neg();
      check($sformatf("t4_mem_req_c%0d", c), 32'(mem_req_o), 32'h1);
      check($sformatf("t4_mem_addr_c%0d", c), mem_addr_o, 32'h300);
      check($sformatf("t4_instr_gnt_c%0d", c), 32'(instr_gnt_o), 32'h0);
      step();
    end
    mem_gnt_i = 1'b1;
    at_neg();
    check("t4_data_gnt_c3", 32'(data_gnt_o), 32'h1);
    check("t4_instr_gnt_c3", 32'(instr_gnt_o), 32'h0);
    step(); data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h13579BDF;
    step(); mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
    step(); instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2468ACE0;
    step(); mem_rvalid_i = 1'b0;

    // Reset during RESP, then a late response
    step(); instr_req_i = 1'b1; instr_addr_i = 32'h500; mem_gnt_i = 1'b1;
    step(); instr_req_i = 1'b0; mem_gnt_i = 1'b0; rst_i = 1'b1;
    step(); rst_i = 1'b0;
    step();
    step(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    at_neg();
    check("t5_instr_rvalid_late", 32'(instr_rvalid_o), 32'h0);
    check("t5_data_rvalid_late", 32'(data_rvalid_o), 32'h0);
    step(); mem_rvalid_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h504; mem_gnt_i = 1'b1;
    at_neg(); check("t5_idle_after_reset", 32'(instr_gnt_o), 32'h1);
    step(); instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0F0F0F0F;
    step(); mem_rvalid_i = 1'b0;

`ifdef RV_ARB_TIMEOUT_EN
    // Fetch never answered: timeout response in RESP cycle TOC
    step(); instr_req_i = 1'b1; instr_addr_i = 32'h600; mem_gnt_i = 1'b1;
    step(); instr_req_i = 1'b0; mem_gnt_i = 1'b0;
    for (int k = 1; k <= TOC; k++) begin
      at_neg();
      check($sformatf("t6_rvalid_resp%0d", k), 32'(instr_rvalid_o), 32'(k == TOC));
      check($sformatf("t6_err_resp%0d", k), 32'(instr_err_o), 32'(k == TOC));
      step();
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
    at_neg(); check("t6_stale_rvalid", 32'(instr_rvalid_o), 32'h0);
    step(); mem_rvalid_i = 1'b0;
`endif

    step(); step();
    at_neg();
    check("end_gnt_queue_empty", 32'(exp_gnt_q.size()), 32'h0);
    check("end_rsp_queue_empty", 32'(exp_rsp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
